traffic_monitor: RTL
====================

# traffic_monitor

Passive checker at the receiving end of the three-wire red/amber/green traffic-light interface produced by the traffic sequencer. It samples the light lines every clock and locks onto the UK sequence R → R+A → G → A → R. Once locked, it flags illegal patterns, out-of-order phases and dwell-time violations, and keeps error and completed-cycle counters. It sits beside the sequencer in the bench or top level, and its outputs feed LEDs or a scoreboard.

## Interface
- MIN_DWELL, 1: minimum consecutive samples a phase must be held before advancing.
- MAX_DWELL, 1: maximum consecutive samples a phase may be held.
- CNT_W, 8: width of dwell, error and cycle counters.
- Legal values: 1 ≤ MIN_DWELL ≤ MAX_DWELL ≤ 2^CNT_W−2.

- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- red  in  1  red lamp; same clock domain, no synchroniser.
- amber  in  1  amber lamp.
- green  in  1  green lamp.
- locked  out  1  high while the FSM is in LOCKED.
- phase  out  2  last accepted phase: 0=R, 1=RA, 2=G, 3=A. Held at 0 in UNLOCKED.
- illegal_err  out  1  one-cycle pulse: illegal lamp pattern sampled.
- seq_err  out  1  one-cycle pulse: legal pattern that is not the successor, sampled while LOCKED.
- dwell_err  out  1  one-cycle pulse: dwell violation while LOCKED.
- err_count  out  CNT_W  samples with any error; saturates at all-ones.
- cycle_count  out  CNT_W  completed error-free cycles; wraps to 0.

## Operation
- Pattern {red,amber,green} classification:
  - Legal: 100=R, 110=RA, 001=G, 010=A.
  - Illegal: 000, 011, 101, 111.
- Successor order: R→RA→G→A→R.
- FSM states: UNLOCKED (reset state), ACQUIRE, LOCKED.
- UNLOCKED:
  - Illegal pattern: stay in UNLOCKED, no error pulse.
  - Legal pattern P: go to ACQUIRE; cur=P; dwell=1.
- ACQUIRE:
  - Pattern equals cur: dwell++ (saturating at all-ones); no checks.
  - Successor of cur: go to LOCKED; cur=succ; dwell=1.
  - Other legal pattern Q: stay in ACQUIRE; cur=Q; dwell=1.
  - Illegal pattern: go to UNLOCKED.
  - No error pulses are generated in ACQUIRE or UNLOCKED.
- LOCKED:
  - Same as cur: dwell++.
    - When dwell goes from MAX_DWELL to MAX_DWELL+1, pulse dwell_err once.
    - Further holding gives no repeat pulse; dwell saturates.
  - Successor: if dwell < MIN_DWELL, pulse dwell_err. Advance either way: cur=succ, dwell=1.
  - Successor A→R with no error on that sample: cycle_count++ (wrap).
  - Other legal pattern Q: pulse seq_err; go to ACQUIRE; cur=Q; dwell=1.
  - Illegal pattern: pulse illegal_err; go to UNLOCKED.
- Error priority within one sample (one error type per sample):
  - illegal_err over seq_err; seq_err over dwell_err.
  - A non-successor change with short dwell reports seq_err only.
- err_count increments by exactly 1 on any sample that raises an error pulse.

## Timing
- All outputs are registered and update on the same rising edge that samples the inputs; there is no extra pipeline stage.
- An error pulse is high for the single cycle after the offending sample edge.
- locked rises after the edge that samples the first correct successor in ACQUIRE.
- locked falls after the edge that samples an illegal or out-of-order pattern.
- Reset:
  - When rst is high at an edge: FSM=UNLOCKED, cur=R, dwell=0.
  - All outputs go to 0 (locked, phase, all three error pulses, err_count, cycle_count).
  - Reset has priority over the inputs sampled on that edge.
  - Reset mid-cycle discards all history; re-lock requires a fresh ACQUIRE.
- Counter boundaries:
  - err_count holds at 2^CNT_W−1.
  - cycle_count wraps from 2^CNT_W−1 to 0.
  - The dwell counter saturates and never wraps.
- With defaults (MIN_DWELL=MAX_DWELL=1), the monitor accepts exactly one sample per phase, matching the sequencer's one-clock phases.

## Test plan
- Reset, then drive 100,110,001,010,100 on 5 edges:
  - locked=1 after edge 2; phase=1 after edge 2, then 2, 3, 0.
  - cycle_count=1 after edge 5; err_count=0.
- While locked (cur=RA), drive 111:
  - illegal_err high for one cycle; locked=0; err_count=1.
  - Then 100,110 re-locks.
- While locked at R, drive 001 (skips RA):
  - seq_err pulse; dwell_err stays 0; locked=0, FSM in ACQUIRE with cur=G.
  - Next sample 010 re-locks.
- MIN_DWELL=2, MAX_DWELL=3; hold G for 5 samples then A:
  - Exactly one dwell_err, on the 4th G sample.
  - The G→A change produces no error; err_count=1.
- Same parameters; G held 1 sample then A:
  - dwell_err pulse; phase advances to 3; locked stays 1.
- CNT_W=2 with continuous sequencer traffic:
  - cycle_count wraps 3→0.
  - After forcing 4 illegal-while-locked events, err_count holds at 3.
  - Asserting rst mid-phase clears all outputs on the next edge.

Source files
------------

// File: rtl/traffic_monitor_if.sv
// Lamp lines from the traffic sequencer to its monitors.
// master drives red/amber/green; slave only observes them.
interface traffic_monitor_if;
   logic red;
   logic amber;
   logic green;

   modport master (output red, output amber, output green);
   modport slave  (input  red, input  amber, input  green);
endinterface

// File: rtl/traffic_monitor.sv
// Passive checker for the UK R -> RA -> G -> A light sequence.
// Ports: clk, rst (sync, high), lamps (slave), locked, phase,
//   illegal_err, seq_err, dwell_err, err_count, cycle_count.
module traffic_monitor #(
   parameter int MIN_DWELL = 1,
   parameter int MAX_DWELL = 1,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   traffic_monitor_if.slave lamps,
   output logic             locked,
   output logic [1:0]       phase,
   output logic             illegal_err,
   output logic             seq_err,
   output logic             dwell_err,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] cycle_count
);

   typedef enum logic [1:0] {
      UNLOCKED,
      ACQUIRE,
      LOCKED
   } state_t;

   localparam logic [1:0] PH_R  = 2'd0;
   localparam logic [1:0] PH_RA = 2'd1;
   localparam logic [1:0] PH_G  = 2'd2;
   localparam logic [1:0] PH_A  = 2'd3;

   localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_DWELL);
   localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_DWELL);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   state_t           state_q, state_d;
   logic [1:0]       cur_q, cur_d;
   logic [CNT_W-1:0] dwell_q, dwell_d;

   logic             vld;
   logic [1:0]       pat;
   logic             same;
   logic             nxt;
   logic [CNT_W-1:0] dwell_inc;

   logic             ill_d;
   logic             seq_d;
   logic             dw_d;
   logic             cyc_d;
   logic             any_err;

   // Lamp pattern decode; phase codes wrap so successor is +1.
   always_comb begin
      vld = 1'b1;
      pat = PH_R;
      case ({lamps.red, lamps.amber, lamps.green})
         3'b100:  pat = PH_R;
         3'b110:  pat = PH_RA;
         3'b001:  pat = PH_G;
         3'b010:  pat = PH_A;
         default: vld = 1'b0;
      endcase
   end

   assign same = vld && (pat == cur_q);
   assign nxt  = vld && (pat == cur_q + 2'd1);

   // Dwell saturates so a long hold never wraps into a false count.
   assign dwell_inc = (dwell_q == '1) ? dwell_q : dwell_q + ONE;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= UNLOCKED;
         cur_q   <= PH_R;
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         dwell_q <= dwell_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      dwell_d = dwell_q;
      unique case (state_q)
         UNLOCKED: begin
            if (vld) begin
               state_d = ACQUIRE;
               cur_d   = pat;
               dwell_d = ONE;
            end
         end
         ACQUIRE: begin
            if (!vld) begin
               state_d = UNLOCKED;
            end else if (same) begin
               dwell_d = dwell_inc;
            end else if (nxt) begin
               state_d = LOCKED;
               cur_d   = pat;
               dwell_d = ONE;
            end else begin
               cur_d   = pat;
               dwell_d = ONE;
            end
         end
         LOCKED: begin
            if (!vld) begin
               state_d = UNLOCKED;
            end else if (same) begin
               dwell_d = dwell_inc;
            end else if (nxt) begin
               cur_d   = pat;
               dwell_d = ONE;
            end else begin
               state_d = ACQUIRE;
               cur_d   = pat;
               dwell_d = ONE;
            end
         end
         default: begin
            state_d = UNLOCKED;
         end
      endcase
   end

   // Output logic; the three error terms are mutually exclusive
   // by construction, which gives the illegal > seq > dwell order.
   always_comb begin
      ill_d = 1'b0;
      seq_d = 1'b0;
      dw_d  = 1'b0;
      cyc_d = 1'b0;
      if (state_q == LOCKED) begin
         ill_d = !vld;
         seq_d = vld && !same && !nxt;
         dw_d  = (same && (dwell_q == MAX_C)) ||
                 (nxt && (dwell_q < MIN_C));
         cyc_d = nxt && (cur_q == PH_A) && !dw_d;
      end
      any_err = ill_d || seq_d || dw_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         locked      <= 1'b0;
         phase       <= PH_R;
         illegal_err <= 1'b0;
         seq_err     <= 1'b0;
         dwell_err   <= 1'b0;
         err_count   <= '0;
         cycle_count <= '0;
      end else begin
         locked      <= (state_d == LOCKED);
         phase       <= (state_d == UNLOCKED) ? PH_R : cur_d;
         illegal_err <= ill_d;
         seq_err     <= seq_d;
         dwell_err   <= dw_d;
         if (any_err && (err_count != '1))
            err_count <= err_count + ONE;
         if (cyc_d)
            cycle_count <= cycle_count + ONE;
      end
   end

endmodule
